// File: rtl/pb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_pkg
//  Description : Shared channel state encoding, counter sizing and timing defaults
//                for the push-button conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package pb_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      RISE_WAIT = 2'd1,
      HIGH      = 2'd2,
      FALL_WAIT = 2'd3
   } pb_state_t;

   localparam int c_N_PBS_DEF           = 3;
   localparam int c_DEBOUNCE_CYCLES_DEF = 16;
   localparam int c_REPEAT_DELAY_DEF    = 64;
   localparam int c_REPEAT_PERIOD_DEF   = 32;

   // The width is sized from the largest count so that one counter width fits
   // every timing value. The extra bit leaves headroom for saturation.
   function automatic int pb_cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pb_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : pb_conditioner_if
//  Description : Button-side and CPU-side signal bundle of the push-button
//                conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pb_conditioner_if
   import pb_pkg::*;
#(
   parameter int N_PBs = c_N_PBS_DEF
);

   logic [N_PBs-1:0] PB_raw;
   logic [N_PBs-1:0] EVENT_CLR;
   logic [N_PBs-1:0] PB_stable;
   logic [N_PBs-1:0] PB_press;
   logic [N_PBs-1:0] PB_event;

   modport master (
      output PB_raw,
      output EVENT_CLR,
      input  PB_stable,
      input  PB_press,
      input  PB_event
   );

   modport slave (
      input  PB_raw,
      input  EVENT_CLR,
      output PB_stable,
      output PB_press,
      output PB_event
   );

endinterface
`default_nettype wire

// File: rtl/pb_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pb_channel
//  Description : One button path. It contains a 2-flop synchroniser, the debounce
//                FSM, the press pulse and the sticky event flag.
//                Auto-repeat is compiled in with macro PB_AUTO_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_channel
   import pb_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = c_REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD_DEF
) (
   input  wire  CLK,
   input  wire  RESET,
   input  wire  i_raw,
   input  wire  i_event_clr,
   output logic o_stable,
   output logic o_press,
   output logic o_event
);

   localparam int              c_CW       = pb_cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
   localparam logic [c_CW-1:0] c_CNT_MAX  = '1;
   localparam logic [c_CW-1:0] c_DEB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

   logic            r_sync1;
   logic            r_sync2;
   pb_state_t       r_state;
   pb_state_t       w_state_nxt;
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cnt_nxt;
   logic [c_CW-1:0] w_cnt_inc;
   logic            w_rise;
   logic            w_press_nxt;
   logic            r_stable;
   logic            r_press;
   logic            r_event;

   assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + c_CNT_ONE);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= LOW;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise      = 1'b0;
      case (r_state)
         LOW: begin
            if (r_sync2) begin
               w_state_nxt = RISE_WAIT;
               w_cnt_nxt   = c_CNT_ONE;
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         RISE_WAIT: begin
            if (!r_sync2) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_DEB_LAST) begin
               w_state_nxt = HIGH;
               w_cnt_nxt   = '0;
               w_rise      = 1'b1;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         HIGH: begin
            if (!r_sync2) begin
               w_state_nxt = FALL_WAIT;
               w_cnt_nxt   = c_CNT_ONE;
            end
         end
         FALL_WAIT: begin
            if (r_sync2) begin
               w_state_nxt = HIGH;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_DEB_LAST) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef PB_AUTO_REPEAT_EN
   localparam logic [c_CW-1:0] c_DLY_LAST = c_CW'(REPEAT_DELAY - 1);
   localparam logic [c_CW-1:0] c_PER_LAST = c_CW'(REPEAT_PERIOD - 1);

   logic [c_CW-1:0] r_rep;
   logic            r_rep_armed;
   logic            w_hold;
   logic            w_rep_fire;

   // Counting starts only once the state is settled in HIGH. Re-entry from
   // FALL_WAIT restarts the delay without a pulse.
   always_comb begin
      w_hold     = (r_state == HIGH) && (w_state_nxt == HIGH);
      w_rep_fire = w_hold && (r_rep == (r_rep_armed ? c_PER_LAST : c_DLY_LAST));
   end

   always_ff @(posedge CLK) begin
      if (RESET || !w_hold) begin
         r_rep       <= '0;
         r_rep_armed <= 1'b0;
      end else if (w_rep_fire) begin
         r_rep       <= '0;
         r_rep_armed <= 1'b1;
      end else begin
         r_rep       <= (r_rep == c_CNT_MAX) ? r_rep : (r_rep + c_CNT_ONE);
      end
   end

   assign w_press_nxt = w_rise | w_rep_fire;
`else
   assign w_press_nxt = w_rise;
`endif

   // Set takes priority over clear, so a press that coincides with a CPU ack is kept.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_press  <= 1'b0;
         r_event  <= 1'b0;
      end else begin
         r_sync1  <= i_raw;
         r_sync2  <= r_sync1;
         r_stable <= (w_state_nxt == HIGH) || (w_state_nxt == FALL_WAIT);
         r_press  <= w_press_nxt;
         r_event  <= r_press | (r_event & ~i_event_clr);
      end
   end

   assign o_stable = r_stable;
   assign o_press  = r_press;
   assign o_event  = r_event;

endmodule
`default_nettype wire

// File: rtl/pb_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : pb_conditioner
//  Description : Conditions N_PBs buttons into a debounced level, a press pulse
//                and a sticky event flag for the Wrapper PB input.
//                Auto-repeat is compiled in with macro PB_AUTO_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_conditioner
   import pb_pkg::*;
#(
   parameter int N_PBs           = c_N_PBS_DEF,
   parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = c_REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD_DEF
) (
   input  wire              CLK,
   input  wire              RESET,
   pb_conditioner_if.slave  pb
);

   logic [N_PBs-1:0] w_stable;
   logic [N_PBs-1:0] w_press;
   logic [N_PBs-1:0] w_event;

   generate
      for (genvar gi = 0; gi < N_PBs; gi++) begin : g_ch
         pb_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
         ) u_ch (
            .CLK         (CLK),
            .RESET       (RESET),
            .i_raw       (pb.PB_raw[gi]),
            .i_event_clr (pb.EVENT_CLR[gi]),
            .o_stable    (w_stable[gi]),
            .o_press     (w_press[gi]),
            .o_event     (w_event[gi])
         );
      end
   endgenerate

   assign pb.PB_stable = w_stable;
   assign pb.PB_press  = w_press;
   assign pb.PB_event  = w_event;

endmodule
`default_nettype wire

// File: tb/tb_pb_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_conditioner
//  Description : Directed self-checking bench for pb_conditioner with
//                DEBOUNCE_CYCLES=4, REPEAT_DELAY=8 and REPEAT_PERIOD=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_conditioner;

   localparam int c_N = 3;

   typedef struct {
      logic [2:0] raw;
      logic [2:0] clr;
      int         n;
      logic [2:0] st;
      logic [2:0] pr;
      logic [2:0] ev;
   } vec_t;

   logic CLK = 1'b0;
   logic RESET;
   int   total = 0;
   int   bad   = 0;
   vec_t tbl[$];

   always #5 CLK = ~CLK;

   pb_conditioner_if #(.N_PBs(c_N)) pb ();

   pb_conditioner #(
      .N_PBs           (c_N),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (4)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .pb    (pb)
   );

   task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [2:0] st, input logic [2:0] pr, input logic [2:0] ev);
      chk({nm, ".stable"}, pb.PB_stable, st);
      chk({nm, ".press"},  pb.PB_press,  pr);
      chk({nm, ".event"},  pb.PB_event,  ev);
   endtask

   // Drive one cycle worth of inputs, then land on the following falling edge.
   task automatic cyc(input logic rst, input logic [2:0] raw, input logic [2:0] clr);
      RESET        = rst;
      pb.PB_raw    = raw;
      pb.EVENT_CLR = clr;
      @(negedge CLK);
   endtask

   task automatic add(input logic [2:0] raw, input logic [2:0] clr, input int n,
                      input logic [2:0] st, input logic [2:0] pr, input logic [2:0] ev);
      vec_t v;
      v.raw = raw; v.clr = clr; v.n = n; v.st = st; v.pr = pr; v.ev = ev;
      tbl.push_back(v);
   endtask

   // Six cycles after reset release with bit0 held, the press must debounce again from scratch.
   task automatic press_after_reset(input string nm, input logic [2:0] ev_before);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 3'b001, 3'b000);
         chk_all($sformatf("%s.r%0d", nm, k), 3'b000, 3'b000, 3'b000);
      end
      cyc(1'b0, 3'b001, 3'b000);
      chk_all({nm, ".r5"}, 3'b001, 3'b001, ev_before);
      cyc(1'b0, 3'b001, 3'b000);
      chk_all({nm, ".r6"}, 3'b001, 3'b000, 3'b001);
   endtask

   initial begin
      logic exp_p;

      // Press bit2 and check the 6-cycle latency
      add(3'b100, 3'b000, 5, 3'b000, 3'b000, 3'b000);
      add(3'b100, 3'b000, 1, 3'b100, 3'b100, 3'b000);
      add(3'b100, 3'b000, 2, 3'b100, 3'b000, 3'b100);
      // bit0 glitch of 3 samples
      add(3'b101, 3'b000, 3, 3'b100, 3'b000, 3'b100);
      add(3'b100, 3'b000, 6, 3'b100, 3'b000, 3'b100);
      // clear, then clear while already 0
      add(3'b100, 3'b100, 1, 3'b100, 3'b000, 3'b000);
      add(3'b100, 3'b000, 2, 3'b100, 3'b000, 3'b000);
      add(3'b100, 3'b100, 1, 3'b100, 3'b000, 3'b000);
      // bouncy release of bit2
      add(3'b000, 3'b000, 2, 3'b100, 3'b000, 3'b000);
      add(3'b100, 3'b000, 2, 3'b100, 3'b000, 3'b000);
      add(3'b000, 3'b000, 2, 3'b100, 3'b000, 3'b000);
      add(3'b100, 3'b000, 2, 3'b100, 3'b000, 3'b000);
      add(3'b000, 3'b000, 5, 3'b100, 3'b000, 3'b000);
      add(3'b000, 3'b000, 3, 3'b000, 3'b000, 3'b000);
      // re-press with clear coinciding with the press pulse
      add(3'b100, 3'b000, 5, 3'b000, 3'b000, 3'b000);
      add(3'b100, 3'b000, 1, 3'b100, 3'b100, 3'b000);
      add(3'b100, 3'b100, 1, 3'b100, 3'b000, 3'b100);
      add(3'b100, 3'b000, 2, 3'b100, 3'b000, 3'b100);
      // simultaneous press of bits 1:0
      add(3'b111, 3'b000, 5, 3'b100, 3'b000, 3'b100);
      add(3'b111, 3'b000, 1, 3'b111, 3'b011, 3'b100);
      add(3'b111, 3'b000, 2, 3'b111, 3'b000, 3'b111);
      // clean release of all, then clear all events
      add(3'b000, 3'b000, 5, 3'b111, 3'b000, 3'b111);
      add(3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b111);
      add(3'b000, 3'b111, 1, 3'b000, 3'b000, 3'b000);
      add(3'b000, 3'b000, 2, 3'b000, 3'b000, 3'b000);

      for (int i = 0; i < 3; i++) cyc(1'b1, 3'b000, 3'b000);
      chk_all("reset", 3'b000, 3'b000, 3'b000);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int j = 0; j < tbl[i].n; j++) begin
            cyc(1'b0, tbl[i].raw, tbl[i].clr);
            chk_all($sformatf("vec%0d.%0d", i, j), tbl[i].st, tbl[i].pr, tbl[i].ev);
         end
      end

      // Reset arrives two cycles into RISE_WAIT with bit0 held
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 3'b001, 3'b000);
         chk_all($sformatf("rw.%0d", k), 3'b000, 3'b000, 3'b000);
      end
      cyc(1'b1, 3'b001, 3'b000);
      chk_all("rw_reset", 3'b000, 3'b000, 3'b000);
      press_after_reset("rw_rel", 3'b000);

      // Hold bit0 and watch for auto-repeat pulses (offset k from the rise)
      for (int k = 2; k < 30; k++) begin
`ifdef PB_AUTO_REPEAT_EN
         exp_p = (k >= 8) && ((k % 4) == 0);
`else
         exp_p = 1'b0;
`endif
         cyc(1'b0, 3'b001, 3'b000);
         chk($sformatf("hold%0d.press", k), pb.PB_press, {2'b00, exp_p});
         chk($sformatf("hold%0d.stable", k), pb.PB_stable, 3'b001);
      end

      // Reset while held in HIGH clears everything, and the press is re-debounced
      cyc(1'b1, 3'b001, 3'b000);
      chk_all("hi_reset", 3'b000, 3'b000, 3'b000);
      press_after_reset("hi_rel", 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
